// File: rtl/spi_master_tx.sv
// SPI mode-0 byte transmitter with frame-level slave select and an enforced CS gap.
// Every output is a flop whose next value is decoded from the next state.
module spi_master_tx #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       busy,
  output logic       byte_done,
  output logic       SCK,
  output logic       SSEL,
  output logic       MOSI
);

  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, NEXT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LD = 8'(CS_GAP - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       last_q, last_d;
  logic       sck_d, ssel_d, mosi_d, ready_d, busy_d, done_d;
  logic       accept, cnt_zero;

  assign accept   = tx_valid && tx_ready;
  assign cnt_zero = (cnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? 8'd0 : cnt_q - 8'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, NEXT: begin
        if (accept) begin
          state_d = SETUP;
          cnt_d   = DIV_LD;
          bit_d   = 3'd7;
          shift_d = tx_data;
          last_d  = tx_last;
        end
      end
      SETUP, SCK_LO: begin
        if (cnt_zero) begin
          state_d = SCK_HI;
          cnt_d   = DIV_LD;
        end
      end
      SCK_HI: begin
        if (cnt_zero) begin
          if (bit_q == 3'd0) begin
            done_d  = 1'b1;
            state_d = last_q ? HOLD : NEXT;
            cnt_d   = last_q ? DIV_LD : 8'd0;
          end else begin
            // Falling edge: present the next lower bit in the same cycle.
            state_d = SCK_LO;
            cnt_d   = DIV_LD;
            bit_d   = bit_q - 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end
      end
      GAP: begin
        if (cnt_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    sck_d   = (state_d == SCK_HI);
    ssel_d  = (state_d == IDLE) || (state_d == GAP);
    ready_d = (state_d == IDLE) || (state_d == NEXT);
    busy_d  = (state_d != IDLE);
    mosi_d  = ssel_d ? 1'b0 : shift_d[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      bit_q     <= 3'd0;
      last_q    <= 1'b0;
      SCK       <= 1'b0;
      SSEL      <= 1'b1;
      MOSI      <= 1'b0;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      last_q    <= last_d;
      SCK       <= sck_d;
      SSEL      <= ssel_d;
      MOSI      <= mosi_d;
      tx_ready  <= ready_d;
      busy      <= busy_d;
      byte_done <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Randomized bench for spi_master_tx: a mode-0 receiver model samples MOSI on SCK rise and
// frame/bit timing is predicted from the SPI framing rules with plain arithmetic.
module tb_spi_master_tx;

  localparam int DIV  = 4;
  localparam int GAPC = 8;
  localparam int DIV2 = 2;
  localparam int GAP2 = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_last, tx_valid2, tx_last2;
  logic       tx_ready, busy, byte_done, sck, ssel, mosi;
  logic       tx_ready2, busy2, byte_done2, sck2, ssel2, mosi2;

  always #5 clk = ~clk;

  spi_master_tx #(.CLK_DIV(DIV), .CS_GAP(GAPC)) u_dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .busy(busy), .byte_done(byte_done),
    .SCK(sck), .SSEL(ssel), .MOSI(mosi)
  );

  spi_master_tx #(.CLK_DIV(DIV2), .CS_GAP(GAP2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_last(tx_last2),
    .tx_ready(tx_ready2), .busy(busy2), .byte_done(byte_done2),
    .SCK(sck2), .SSEL(ssel2), .MOSI(mosi2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Receiver / timing monitor for the CLK_DIV=4 instance
  logic [7:0] q_rx[$];
  int hi_w[$], lo_w[$], ssel_lo_w[$], ssel_hi_w[$], first_rise[$], done_at[$];
  int done_cnt = 0, mosi_bad = 0, rise_cnt = 0, rdy_busy = 0;
  int hi_run = 0, lo_run = 0, sl_run = 0, sh_run = 0, nbit = 0, fbit = 0;
  logic p_sck = 1'b0, p_ssel = 1'b1, p_mosi = 1'b0;
  logic [7:0] rx_sh = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      nbit = 0; fbit = 0; sl_run = 0;
    end else begin
      if (!ssel && p_ssel) begin ssel_hi_w.push_back(sh_run); sl_run = 0; end
      if (ssel && !p_ssel) begin ssel_lo_w.push_back(sl_run); sh_run = 0; nbit = 0; fbit = 0; end
      if (mosi !== p_mosi && sck) mosi_bad++;
      if (tx_ready && busy) rdy_busy++;
      if (byte_done) begin done_cnt++; done_at.push_back(sl_run); end
      if (sck && !p_sck) begin
        if (fbit == 0) first_rise.push_back(sl_run);
        if (nbit != 0) lo_w.push_back(lo_run);
        rx_sh = {rx_sh[6:0], mosi};
        nbit++; fbit++; rise_cnt++; hi_run = 0;
        if (nbit == 8) begin q_rx.push_back(rx_sh); nbit = 0; end
      end
      if (!sck && p_sck) begin hi_w.push_back(hi_run); lo_run = 0; end
      if (sck) hi_run++; else lo_run++;
      if (ssel) sh_run++; else sl_run++;
    end
    p_sck = sck; p_ssel = ssel; p_mosi = mosi;
  end

  // Lighter monitor for the CLK_DIV=2 instance
  logic [7:0] q_rx2[$];
  int hi2 = 0, lo2 = 0, nb2 = 0, hi2_bad = 0, lo2_bad = 0, mosi2_bad = 0, rise2 = 0, done2 = 0;
  logic p_sck2 = 1'b0, p_mosi2 = 1'b0;
  logic [7:0] sh2 = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ssel2) nb2 = 0;
      if (mosi2 !== p_mosi2 && sck2) mosi2_bad++;
      if (byte_done2) done2++;
      if (sck2 && !p_sck2) begin
        if (nb2 != 0 && lo2 != DIV2) lo2_bad++;
        sh2 = {sh2[6:0], mosi2};
        hi2 = 0; rise2++; nb2++;
        if (nb2 == 8) begin q_rx2.push_back(sh2); nb2 = 0; end
      end
      if (!sck2 && p_sck2) begin
        if (hi2 != DIV2) hi2_bad++;
        lo2 = 0;
      end
      if (sck2) hi2++; else lo2++;
    end
    p_sck2 = sck2; p_mosi2 = mosi2;
  end

  task automatic send(input int u, input logic [7:0] d, input logic l);
    int   t;
    bit   ok;
    logic r;
    t = 0; ok = 1'b0;
    if (u == 0) begin tx_data = d; tx_last = l; tx_valid = 1'b1; end
    else begin tx_data2 = d; tx_last2 = l; tx_valid2 = 1'b1; end
    while (!ok && t < 3000) begin
      r = (u == 0) ? tx_ready : tx_ready2;
      @(posedge clk); #1;
      t++;
      ok = r;
    end
    tx_valid = 1'b0; tx_valid2 = 1'b0;
    tx_data = 8'($urandom); tx_data2 = 8'($urandom);
    tx_last = 1'($urandom); tx_last2 = 1'($urandom);
    check_eq("accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int u);
    int t;
    t = 0;
    while (((u == 0) ? busy : busy2) && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("idle_reached", 32'(t < 5000), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_q[$];
  logic [7:0] v;
  int flen[6];
  int r0, h0, l0, lo0, hi0, d0, f0, a0, rb0, base, t, bad, len, nbytes, stall_bad;

  initial begin
    rst_n = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; tx_last = 1'b0;
    tx_data2 = 8'h00; tx_valid2 = 1'b0; tx_last2 = 1'b0;
    #22;
    check_eq("reset_outputs", 32'({ssel, sck, mosi, tx_ready, busy, byte_done}), 32'b100000);
    check_eq("reset_outputs2", 32'({ssel2, sck2, mosi2, tx_ready2, busy2, byte_done2}), 32'b100000);
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    check_eq("ready_before_edge", 32'(tx_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("ready_after_reset", 32'(tx_ready), 32'd1);

    // Single byte, closed frame
    r0 = q_rx.size(); h0 = hi_w.size(); l0 = lo_w.size(); lo0 = ssel_lo_w.size();
    d0 = done_cnt; f0 = first_rise.size(); a0 = done_at.size(); rb0 = rdy_busy;
    send(0, 8'hA5, 1'b1);
    wait_idle(0);
    check_eq("single_rx", (q_rx.size() > r0) ? 32'(q_rx[r0]) : 32'hFFFF, 32'hA5);
    check_eq("single_ssel_low", (ssel_lo_w.size() > lo0) ? 32'(ssel_lo_w[lo0]) : 32'hFFFF, 32'(17 * DIV));
    check_eq("single_sck_pulses", 32'(hi_w.size() - h0), 32'd8);
    bad = 0;
    for (int i = h0; i < hi_w.size(); i++) if (hi_w[i] != DIV) bad++;
    check_eq("single_sck_high_width", 32'(bad), 32'd0);
    check_eq("single_sck_low_count", 32'(lo_w.size() - l0), 32'd7);
    bad = 0;
    for (int i = l0; i < lo_w.size(); i++) if (lo_w[i] != DIV) bad++;
    check_eq("single_sck_low_width", 32'(bad), 32'd0);
    check_eq("single_first_rise", (first_rise.size() > f0) ? 32'(first_rise[f0]) : 32'hFFFF, 32'(DIV));
    check_eq("single_done_time", (done_at.size() > a0) ? 32'(done_at[a0]) : 32'hFFFF, 32'(16 * DIV));
    check_eq("single_done_count", 32'(done_cnt - d0), 32'd1);
    check_eq("single_ready_in_frame", 32'(rdy_busy - rb0), 32'd0);

    // Burst with valid held
    r0 = q_rx.size(); lo0 = ssel_lo_w.size(); rb0 = rdy_busy;
    send(0, 8'h01, 1'b0);
    send(0, 8'h80, 1'b0);
    send(0, 8'hFF, 1'b1);
    wait_idle(0);
    check_eq("burst_rx0", (q_rx.size() > r0) ? 32'(q_rx[r0]) : 32'hFFFF, 32'h01);
    check_eq("burst_rx1", (q_rx.size() > r0 + 1) ? 32'(q_rx[r0 + 1]) : 32'hFFFF, 32'h80);
    check_eq("burst_rx2", (q_rx.size() > r0 + 2) ? 32'(q_rx[r0 + 2]) : 32'hFFFF, 32'hFF);
    check_eq("burst_one_frame", 32'(ssel_lo_w.size() - lo0), 32'd1);
    check_eq("burst_ssel_low", (ssel_lo_w.size() > lo0) ? 32'(ssel_lo_w[lo0]) : 32'hFFFF,
             32'(3 * 16 * DIV + 2 + DIV));
    check_eq("burst_next_ready_cycles", 32'(rdy_busy - rb0), 32'd2);

    // Stall in NEXT
    r0 = q_rx.size(); lo0 = ssel_lo_w.size();
    send(0, 8'h3C, 1'b0);
    t = 0;
    while (!tx_ready && t < 1000) begin @(posedge clk); #1; t++; end
    check_eq("stall_reach_next", 32'(tx_ready), 32'd1);
    stall_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (sck || ssel || !tx_ready || !busy) stall_bad++;
    end
    check_eq("stall_lines_held", 32'(stall_bad), 32'd0);
    send(0, 8'hC3, 1'b1);
    wait_idle(0);
    check_eq("stall_rx0", (q_rx.size() > r0) ? 32'(q_rx[r0]) : 32'hFFFF, 32'h3C);
    check_eq("stall_rx1", (q_rx.size() > r0 + 1) ? 32'(q_rx[r0 + 1]) : 32'hFFFF, 32'hC3);
    check_eq("stall_one_frame", 32'(ssel_lo_w.size() - lo0), 32'd1);

    // Random back-to-back frames with valid offered continuously
    r0 = q_rx.size(); lo0 = ssel_lo_w.size(); hi0 = ssel_hi_w.size(); d0 = done_cnt; rb0 = rdy_busy;
    exp_q.delete();
    nbytes = 0;
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 4);
      flen[f] = len;
      nbytes += len;
      for (int b = 0; b < len; b++) begin
        v = 8'($urandom);
        exp_q.push_back(v);
        send(0, v, b == len - 1);
      end
    end
    wait_idle(0);
    check_eq("rand_rx_count", 32'(q_rx.size() - r0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (r0 + i < q_rx.size()) check_eq("rand_rx", 32'(q_rx[r0 + i]), 32'(exp_q[i]));
    check_eq("rand_frames", 32'(ssel_lo_w.size() - lo0), 32'd6);
    for (int f = 0; f < 6; f++)
      if (lo0 + f < ssel_lo_w.size())
        check_eq("rand_ssel_low", 32'(ssel_lo_w[lo0 + f]), 32'(flen[f] * 16 * DIV + flen[f] - 1 + DIV));
    for (int f = 1; f < 6; f++)
      if (hi0 + f < ssel_hi_w.size())
        check_eq("rand_cs_gap", 32'(ssel_hi_w[hi0 + f]), 32'(GAPC + 1));
    check_eq("rand_done_count", 32'(done_cnt - d0), 32'(nbytes));
    check_eq("rand_ready_in_frame", 32'(rdy_busy - rb0), 32'(nbytes - 6));
    check_eq("mosi_stable_while_sck_high", 32'(mosi_bad), 32'd0);

    // Asynchronous reset at bit 4
    r0 = q_rx.size(); base = rise_cnt;
    send(0, 8'h5A, 1'b1);
    t = 0;
    while (rise_cnt < base + 4 && t < 1000) begin @(negedge clk); #2; t++; end
    check_eq("pre_reset_mid_bit", 32'({sck, ssel}), 32'b10);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_lines", 32'({ssel, sck, busy, tx_ready}), 32'b1000);
    @(negedge clk); @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 8'h96, 1'b1);
    wait_idle(0);
    check_eq("post_reset_rx_count", 32'(q_rx.size() - r0), 32'd1);
    check_eq("post_reset_rx", (q_rx.size() > r0) ? 32'(q_rx[r0]) : 32'hFFFF, 32'h96);

    // Minimum divider instance
    r0 = q_rx2.size(); base = rise2; d0 = done2;
    exp_q.delete();
    for (int b = 0; b < 3; b++) begin
      v = 8'($urandom);
      exp_q.push_back(v);
      send(1, v, b == 2);
    end
    wait_idle(1);
    check_eq("div2_rx_count", 32'(q_rx2.size() - r0), 32'd3);
    for (int i = 0; i < 3; i++)
      if (r0 + i < q_rx2.size()) check_eq("div2_rx", 32'(q_rx2[r0 + i]), 32'(exp_q[i]));
    check_eq("div2_rises", 32'(rise2 - base), 32'd24);
    check_eq("div2_high_width", 32'(hi2_bad), 32'd0);
    check_eq("div2_low_width", 32'(lo2_bad), 32'd0);
    check_eq("div2_mosi_stable", 32'(mosi2_bad), 32'd0);
    check_eq("div2_done_count", 32'(done2 - d0), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
